// File: rtl/finder_pkg.sv
// Shared definitions for the instruction fetch path and its controller.
//   fetch_state_t   : fetch sequencer states
//   WIDTH_INSTR_DEF : default instruction word width
//   WA_IM_DEF       : default instruction-memory address width
package finder_pkg;

   localparam int WIDTH_INSTR_DEF = 16;
   localparam int WA_IM_DEF       = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Two-entry instruction FIFO with flush and a pass-through path.
// A word arriving while the FIFO is empty is offered at once and is only
// stored if it is not taken in that same cycle.
//   clk, rst      : clock, synchronous active-high reset
//   i_flush       : drop all stored entries and any word arriving now
//   i_push/i_data : arriving word
//   i_pop         : head accepted this cycle
//   o_valid       : an entry (stored or arriving) is available
//   o_head        : head entry, zero when nothing is available
//   o_level_next  : stored entries after this clock edge
module instr_fifo #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_level_next
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_empty;
   logic             w_store;
   logic             w_advance;

   assign w_empty      = (r_count == 2'd0);
   assign w_store      = i_push & ~(w_empty & i_pop);
   assign w_advance    = i_pop & ~w_empty;
   assign o_valid      = ~w_empty | i_push;
   assign o_level_next = r_count + 2'(w_store) - 2'(w_advance);

   always_comb begin
      o_head = '0;
      if (!w_empty) begin
         o_head = r_mem[r_rd_ptr];
      end else if (i_push) begin
         o_head = i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_store) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_advance) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= o_level_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads a program from a 1-cycle-latency
// instruction memory and offers it to the controller with valid/next_instr.
//   clk, rst                   : clock, synchronous active-high reset
//   start, start_addr          : launch a program (IDLE only)
//   last_addr                  : address of the final program instruction
//   im_en, im_addr, im_rdata   : instruction-memory read port
//   instr, valid, next_instr   : instruction handshake to the controller
//   jump, jump_addr            : redirect, sampled on a transfer
//   busy, done                 : not-IDLE flag, completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | fetching sequentially from pc
// DRAIN | last_addr issued, delivering the remaining instructions
module instr_fetch
   import finder_pkg::*;
#(
   parameter int WIDTH_INSTR = WIDTH_INSTR_DEF,
   parameter int WA_IM       = WA_IM_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [WA_IM-1:0]       start_addr,
   input  logic [WA_IM-1:0]       last_addr,
   output logic                   im_en,
   output logic [WA_IM-1:0]       im_addr,
   input  logic [WIDTH_INSTR-1:0] im_rdata,
   output logic [WIDTH_INSTR-1:0] instr,
   output logic                   valid,
   input  logic                   next_instr,
   input  logic                   jump,
   input  logic [WA_IM-1:0]       jump_addr,
   output logic                   busy,
   output logic                   done
);

   fetch_state_t         r_state;
   logic [WA_IM-1:0]     r_pc;
   logic                 r_inflight;
   logic                 r_inflight_last;
   logic                 r_done;
   logic                 w_xfer;
   logic                 w_jump_xfer;
   logic                 w_last_xfer;
   logic                 w_issue;
   logic [1:0]           w_level_next;
   logic [WIDTH_INSTR:0] w_head;

   // Entries carry a last-tag bit above the instruction word.
   instr_fifo #(.WIDTH(WIDTH_INSTR + 1)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (w_jump_xfer),
      .i_push       (r_inflight),
      .i_data       ({r_inflight_last, im_rdata}),
      .i_pop        (w_xfer),
      .o_valid      (valid),
      .o_head       (w_head),
      .o_level_next (w_level_next)
   );

   assign instr       = w_head[WIDTH_INSTR-1:0];
   assign w_xfer      = valid & next_instr;
   assign w_jump_xfer = w_xfer & jump;
   assign w_last_xfer = w_xfer & ~jump & w_head[WIDTH_INSTR];

   // Issue only if the word can still be absorbed once it returns; counting
   // this cycle's pop keeps one instruction per cycle with next_instr held.
   assign w_issue = (r_state == RUN) & ~w_jump_xfer & (w_level_next < 2'd2);

   assign im_en   = w_issue;
   assign im_addr = r_pc;
   assign busy    = (r_state != IDLE);
   assign done    = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_pc            <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done          <= 1'b0;
         // A jump suppresses issue, so the read returning next cycle is dropped.
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue & (r_pc == last_addr);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_pc    <= start_addr;
                  r_state <= RUN;
               end
            end
            RUN, DRAIN: begin
               if (w_jump_xfer) begin
                  r_pc    <= jump_addr;
                  r_state <= RUN;
               end else if (w_last_xfer) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end else if (w_issue) begin
                  r_pc <= r_pc + WA_IM'(1);
                  if (r_pc == last_addr) begin
                     r_state <= DRAIN;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: program table, directed corner sequences and a
// randomized run against a transaction-level model of the fetch stream.
module tb_instr_fetch;

   localparam int WI = 16;
   localparam int WA = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [WA-1:0] start_addr;
   logic [WA-1:0] last_addr;
   logic          im_en;
   logic [WA-1:0] im_addr;
   logic [WI-1:0] im_rdata;
   logic [WI-1:0] instr;
   logic          valid;
   logic          next_instr;
   logic          jump;
   logic [WA-1:0] jump_addr;
   logic          busy;
   logic          done;

   logic [WI-1:0] mem [256];
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [WA-1:0] s;
      logic [WA-1:0] l;
      int            len;
      bit            poke;
   } prog_t;
   prog_t tbl [6];

   logic [WA-1:0] a_tmp;
   logic          m_busy;
   logic          m_done_due;
   logic          m_fetch_done;
   logic          p_hold;
   logic          xfer;
   logic [WA-1:0] m_exp;
   logic [WA-1:0] m_fetch;
   logic [WA-1:0] m_last;
   logic [WI-1:0] p_instr;
   int            m_out;

   instr_fetch #(.WIDTH_INSTR(WI), .WA_IM(WA)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .last_addr  (last_addr),
      .im_en      (im_en),
      .im_addr    (im_addr),
      .im_rdata   (im_rdata),
      .instr      (instr),
      .valid      (valid),
      .next_instr (next_instr),
      .jump       (jump),
      .jump_addr  (jump_addr),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // 1-cycle-latency memory; garbage on the bus when not reading.
   always @(posedge clk) begin
      if (im_en) im_rdata <= mem[im_addr];
      else       im_rdata <= 16'($urandom);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_im_en"},   32'(im_en),   0);
      check({tag, "_im_addr"}, 32'(im_addr), 0);
      check({tag, "_valid"},   32'(valid),   0);
      check({tag, "_instr"},   32'(instr),   0);
      check({tag, "_busy"},    32'(busy),    0);
      check({tag, "_done"},    32'(done),    0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; next_instr = 1'b0; jump = 1'b0;
      start_addr = '0; last_addr = '0; jump_addr = '0;
      for (int a = 0; a < 256; a++) mem[a] = {8'(a), 8'($urandom)};

      tbl[0] = '{8'h10, 8'h13, 4, 1'b0};
      tbl[1] = '{8'hFE, 8'h01, 4, 1'b0};
      tbl[2] = '{8'h20, 8'h20, 1, 1'b0};
      tbl[3] = '{8'h80, 8'h85, 6, 1'b1};
      tbl[4] = '{8'hFF, 8'hFF, 1, 1'b0};
      tbl[5] = '{8'h00, 8'h02, 3, 1'b1};

      // reset state
      @(negedge clk);
      @(negedge clk); #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // program table: latency, streaming, wrap, done pulse, ignored start
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         start = 1'b1; start_addr = tbl[t].s; last_addr = tbl[t].l;
         next_instr = 1'b1; jump = 1'b0; #1;
         check("tbl_idle_busy", 32'(busy), 0);
         @(negedge clk); start = 1'b0; start_addr = 8'hAA; #1;
         check("tbl_lat_im_en", 32'(im_en), 1);
         check("tbl_lat_im_addr", 32'(im_addr), 32'(tbl[t].s));
         check("tbl_lat_valid", 32'(valid), 0);
         for (int i = 0; i < tbl[t].len; i++) begin
            @(negedge clk);
            if (tbl[t].poke && i == 1) begin
               start = 1'b1; start_addr = 8'h33;
            end else begin
               start = 1'b0;
            end
            #1;
            a_tmp = tbl[t].s + 8'(i);
            check("tbl_valid", 32'(valid), 1);
            check("tbl_instr", 32'(instr), 32'(mem[a_tmp]));
         end
         @(negedge clk); start = 1'b0; #1;
         check("tbl_done", 32'(done), 1);
         check("tbl_busy_after", 32'(busy), 0);
         check("tbl_valid_after", 32'(valid), 0);
         @(negedge clk); #1;
         check("tbl_done_once", 32'(done), 0);
      end

      // stall for 5 cycles mid-program
      @(negedge clk);
      start = 1'b1; start_addr = 8'h50; last_addr = 8'h5A; next_instr = 1'b1; #1;
      @(negedge clk); start = 1'b0; #1;
      @(negedge clk); #1;
      check("stall_pre0", 32'(instr), 32'(mem[8'h50]));
      @(negedge clk); #1;
      check("stall_pre1", 32'(instr), 32'(mem[8'h51]));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); next_instr = 1'b0; #1;
         check("stall_valid", 32'(valid), 1);
         check("stall_instr", 32'(instr), 32'(mem[8'h52]));
         if (k >= 1) check("stall_im_en", 32'(im_en), 0);
      end
      for (int k = 0; k < 9; k++) begin
         @(negedge clk); next_instr = 1'b1; #1;
         a_tmp = 8'h52 + 8'(k);
         check("stall_resume_valid", 32'(valid), 1);
         check("stall_resume_instr", 32'(instr), 32'(mem[a_tmp]));
      end
      @(negedge clk); #1;
      check("stall_done", 32'(done), 1);
      check("stall_busy", 32'(busy), 0);

      // jump on transfer of 0x12
      @(negedge clk);
      start = 1'b1; start_addr = 8'h10; last_addr = 8'h13; next_instr = 1'b1; #1;
      @(negedge clk); start = 1'b0; #1;
      @(negedge clk); #1;
      check("jmp_i10", 32'(instr), 32'(mem[8'h10]));
      @(negedge clk); #1;
      check("jmp_i11", 32'(instr), 32'(mem[8'h11]));
      @(negedge clk); jump = 1'b1; jump_addr = 8'h40; last_addr = 8'h42; #1;
      check("jmp_i12", 32'(instr), 32'(mem[8'h12]));
      @(negedge clk); jump = 1'b0; #1;
      check("jmp_im_en", 32'(im_en), 1);
      check("jmp_im_addr", 32'(im_addr), 32'h40);
      check("jmp_flushed", 32'(valid), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         a_tmp = 8'h40 + 8'(k);
         check("jmp_valid", 32'(valid), 1);
         check("jmp_instr", 32'(instr), 32'(mem[a_tmp]));
      end
      @(negedge clk); #1;
      check("jmp_done", 32'(done), 1);

      // reset with FIFO full and a read in flight
      @(negedge clk);
      start = 1'b1; start_addr = 8'h60; last_addr = 8'h70; next_instr = 1'b0; #1;
      @(negedge clk); start = 1'b0; #1;
      @(negedge clk); #1;
      check("rst_first", 32'(instr), 32'(mem[8'h60]));
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("rst_full_instr", 32'(instr), 32'(mem[8'h60]));
      check("rst_full_im_en", 32'(im_en), 0);
      @(negedge clk); next_instr = 1'b1; rst = 1'b1; #1;
      check("rst_issue_im_en", 32'(im_en), 1);
      check("rst_issue_addr", 32'(im_addr), 32'h62);
      @(negedge clk); rst = 1'b0; next_instr = 1'b0; #1;
      check_reset_outputs("rst_mid");
      @(negedge clk); #1;
      check("rst_after_valid", 32'(valid), 0);
      check("rst_after_busy", 32'(busy), 0);

      // randomized run against the fetch-stream model
      m_busy = 1'b0; m_done_due = 1'b0; m_fetch_done = 1'b0; p_hold = 1'b0;
      m_out = 0; m_exp = '0; m_fetch = '0; m_last = '0; p_instr = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         start = 1'b0; jump = 1'b0;
         if (!m_busy && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            start_addr = 8'($urandom);
            last_addr = start_addr + 8'($urandom_range(0, 10));
         end else if (m_busy && $urandom_range(0, 29) == 0) begin
            start = 1'b1;
            start_addr = 8'($urandom);
         end
         next_instr = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            jump = 1'b1;
            jump_addr = last_addr - 8'($urandom_range(0, 6));
         end
         #1;
         check("rnd_busy", 32'(busy), 32'(m_busy));
         check("rnd_done", 32'(done), 32'(m_done_due));
         if (!m_busy) check("rnd_idle_valid", 32'(valid), 0);
         if (p_hold) begin
            check("rnd_hold_valid", 32'(valid), 1);
            check("rnd_hold_instr", 32'(instr), 32'(p_instr));
         end
         xfer = valid && next_instr;
         if (im_en) begin
            check("rnd_fetch_addr", 32'(im_addr), 32'(m_fetch));
            check("rnd_fetch_room", 32'(!m_fetch_done && (m_out - int'(xfer)) < 2), 1);
            if (m_fetch == m_last) m_fetch_done = 1'b1;
            m_fetch = m_fetch + 8'd1;
            m_out++;
         end
         m_done_due = 1'b0;
         if (xfer && m_busy) begin
            check("rnd_instr", 32'(instr), 32'(mem[m_exp]));
            m_out--;
            if (jump) begin
               m_exp = jump_addr; m_fetch = jump_addr; m_out = 0; m_fetch_done = 1'b0;
            end else if (m_exp == m_last) begin
               m_busy = 1'b0; m_done_due = 1'b1;
            end else begin
               m_exp = m_exp + 8'd1;
            end
         end else if (start && !m_busy) begin
            m_busy = 1'b1; m_exp = start_addr; m_fetch = start_addr;
            m_last = last_addr; m_out = 0; m_fetch_done = 1'b0;
         end
         p_hold  = valid && !next_instr;
         p_instr = instr;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter WIDTH_INSTR, default 16, instruction word width.
REQ-002 The module SHALL have parameter WA_IM, default 8, instruction-memory address width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1, begin fetching; honoured only in IDLE.
REQ-006 The module SHALL have port start_addr, input, WA_IM, first fetch address.
REQ-007 The module SHALL have port last_addr, input, WA_IM, address of final program instruction.
REQ-008 The module SHALL have port im_en, output, 1, instruction-memory read enable.
REQ-009 The module SHALL have port im_addr, output, WA_IM, instruction-memory read address.
REQ-010 The module SHALL have port im_rdata, input, WIDTH_INSTR, read data, valid exactly 1 cycle after im_en.
REQ-011 The module SHALL have port instr, output, WIDTH_INSTR, instruction offered to the controller.
REQ-012 The module SHALL have port valid, output, 1, instr is valid.
REQ-013 The module SHALL have port next_instr, input, 1, controller accepts instr.
REQ-014 The module SHALL have port jump, input, 1, accepted instruction redirects fetch.
REQ-015 The module SHALL have port jump_addr, input, WA_IM, redirect target.
REQ-016 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 The module SHALL have port done, output, 1, one-cycle pulse at program completion.

Function
REQ-018 Transfer SHALL occur in a cycle where valid and next_instr are both 1; jump is sampled only on a transfer.
REQ-019 States SHALL be IDLE, RUN, DRAIN; start in IDLE: pc<=start_addr, go RUN.
REQ-020 In RUN, im_en SHALL assert with im_addr=pc when buffered entries plus in-flight reads is <2; pc then increments modulo 2**WA_IM (wrap 0xFF->0x00).
REQ-021 Returned im_rdata SHALL be written into a 2-entry FIFO with a last-tag bit set when its address equalled last_addr.
REQ-022 valid SHALL equal FIFO non-empty; instr SHALL be FIFO head, 0 when empty.
REQ-023 Start-to-valid latency SHALL be 2 cycles (start at T, im_en at T+1, valid at T+2); with next_instr held 1, throughput SHALL be one instruction per cycle.
REQ-024 valid and instr SHALL stay stable while next_instr=0; no read SHALL be issued that the FIFO cannot absorb.
REQ-025 Issuing the read of last_addr SHALL move RUN->DRAIN; DRAIN issues no reads.
REQ-026 Transfer of a last-tagged entry without jump SHALL move to IDLE and pulse done the next cycle.
REQ-027 Transfer with jump=1 (any state but IDLE) SHALL flush the FIFO, discard any in-flight read, set pc<=jump_addr, enter RUN; jump at T -> im_en(jump_addr) at T+1 -> valid at T+2.
REQ-028 start while busy SHALL be ignored; jump without transfer SHALL be ignored.

Reset
REQ-029 On rst: state IDLE, pc 0, FIFO empty, in-flight cleared, im_en 0, im_addr 0, valid 0, instr 0, busy 0, done 0.
REQ-030 rst mid-operation SHALL discard in-flight im_rdata returning the following cycle.

Structure
REQ-031 Package finder_pkg SHALL hold the fetch_state_t enum (IDLE, RUN, DRAIN) and the default width constants shared with the controller.
REQ-032 The 2-entry FIFO with flush SHALL be sub-module instr_fifo.

Verification
REQ-033 start_addr=0x10, last_addr=0x13, next_instr=1 -> instr of 0x10..0x13 on 4 consecutive cycles from T+2, done pulse once, busy low after.
REQ-034 next_instr=0 for 5 cycles mid-program -> valid held, instr unchanged, im_en low once FIFO full, no instruction lost or duplicated.
REQ-035 jump=1 on transfer of 0x12 with jump_addr=0x40 -> instruction from 0x13 never offered, im_addr=0x40 next cycle, its instr valid 2 cycles after jump.
REQ-036 start_addr=0xFE, last_addr=0x01 -> addresses 0xFE,0xFF,0x00,0x01 fetched in order, done.
REQ-037 rst asserted with FIFO full and a read in flight -> all outputs at reset values next cycle, stale im_rdata not offered.
REQ-038 start pulsed while busy -> ignored, pc sequence unchanged.
